// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional perf counters (perf_bubbles, perf_flushes) when ID_EX_PERF_COUNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instruction,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_if_id,
  output logic            ex_valid,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
`ifdef ID_EX_PERF_COUNT_EN
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_flushes,
`endif
  output logic [6:0]      ex_funct7
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, load_use, id_ctl_en;

  assign opcode = id_instruction[6:0];
  assign rs1    = id_instruction[19:15];
  assign rs2    = id_instruction[24:20];
  assign rd     = id_instruction[11:7];

  assign use_rs1 = (opcode == OP_R) || (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                   (opcode == OP_BRANCH) || (opcode == OP_IMM);
  assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // x0 as a load destination never creates a real dependency
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));

  assign stall_if_id = !flush && (hold || load_use);
  assign id_ctl_en   = id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
    end else if (flush || (!hold && load_use)) begin
      // bubble: data/index fields keep their stale values
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_write  <= 1'b0;
    end else if (!hold) begin
      ex_valid      <= id_valid;
      ex_branch     <= id_branch     && id_ctl_en;
      ex_mem_read   <= id_mem_read   && id_ctl_en;
      ex_mem_to_reg <= id_mem_to_reg && id_ctl_en;
      ex_mem_write  <= id_mem_write  && id_ctl_en;
      ex_alu_src    <= id_alu_src    && id_ctl_en;
      ex_reg_write  <= id_reg_write  && id_ctl_en;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= rs1;
      ex_rs2        <= rs2;
      ex_rd         <= rd;
      ex_funct3     <= id_instruction[14:12];
      ex_funct7     <= id_instruction[31:25];
    end
  end

`ifdef ID_EX_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else if (flush) begin
      perf_flushes <= perf_flushes + 32'd1;
    end else if (!hold && load_use) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule
